// File: rtl/lut_eval_seq.sv
// lut_eval_seq: programmable N_IN-input truth-table evaluator.
//
// A 2^N_IN-bit table is shifted in serially. Registered lookups use a
// valid/ready handshake with one cycle of latency. A self-sweep walks
// every table entry once and counts the ones, so the loaded function can
// be checked on-chip.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   cfg_we       shift cfg_bit into the table (IDLE only)
//   cfg_bit      serial table data
//   in_valid     lookup request
//   in_data      lookup address, bit 0 = first function input
//   in_ready     lookup can be accepted (decoded from state, IDLE)
//   out_valid    one-cycle pulse qualifying out_y
//   out_y        registered function value, holds between lookups
//   sweep_start  begin a sweep (IDLE only)
//   sweep_busy   sweep in progress (SWEEP or DONE)
//   sweep_done   one-cycle pulse when ones_count is final
//   ones_count   number of 1 entries found by the last sweep

module lut_eval_seq #(
  parameter int unsigned N_IN  = 6,
  parameter int unsigned CNT_W = N_IN + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic             cfg_bit,
  input  logic             in_valid,
  input  logic [N_IN-1:0]  in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic             out_y,
  input  logic             sweep_start,
  output logic             sweep_busy,
  output logic             sweep_done,
  output logic [CNT_W-1:0] ones_count
);

  localparam int unsigned DEPTH = 2 ** N_IN;
  localparam logic [N_IN-1:0] IDX_LAST = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [DEPTH-1:0] table_q, table_d;
  logic [N_IN-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0] ones_q, ones_d;
  logic             out_valid_q, out_valid_d;
  logic             out_y_q, out_y_d;
  logic             done_q, done_d;

  // Control strobes decoded from the current state
  logic idle;
  logic lookup_acc;
  logic cfg_shift;
  logic sweep_go;
  logic sweep_step;
  logic sweep_last;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sweep_start) begin
          state_d = ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        if (idx_q == IDX_LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State decode: handshake and sweep strobes
  always_comb begin
    idle       = 1'b0;
    sweep_busy = 1'b0;
    sweep_step = 1'b0;
    unique case (state_q)
      ST_IDLE:  idle       = 1'b1;
      ST_SWEEP: begin
        sweep_busy = 1'b1;
        sweep_step = 1'b1;
      end
      ST_DONE:  sweep_busy = 1'b1;
      default:  idle       = 1'b0;
    endcase
    in_ready   = idle;
    lookup_acc = in_valid & idle;
    cfg_shift  = cfg_we & idle;
    sweep_go   = sweep_start & idle;
    sweep_last = sweep_step & (idx_q == IDX_LAST);
  end

  // Datapath next-state: table shift, lookup, sweep counting
  always_comb begin
    table_d     = table_q;
    idx_d       = idx_q;
    ones_d      = ones_q;
    out_valid_d = 1'b0;
    out_y_d     = out_y_q;
    done_d      = 1'b0;

    // Lookup reads the pre-shift table when a config write coincides
    if (lookup_acc) begin
      out_valid_d = 1'b1;
      out_y_d     = table_q[in_data];
    end

    if (cfg_shift) begin
      table_d = {table_q[DEPTH-2:0], cfg_bit};
    end

    if (sweep_go) begin
      idx_d  = '0;
      ones_d = '0;
    end else if (sweep_step) begin
      ones_d = ones_q + CNT_W'(table_q[idx_q]);
      // Index parks on the last entry rather than wrapping
      if (!sweep_last) begin
        idx_d = idx_q + N_IN'(1);
      end
    end

    done_d = sweep_last;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      table_q     <= '0;
      idx_q       <= '0;
      ones_q      <= '0;
      out_valid_q <= 1'b0;
      out_y_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      table_q     <= table_d;
      idx_q       <= idx_d;
      ones_q      <= ones_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      done_q      <= done_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_y      = out_y_q;
  assign sweep_done = done_q;
  assign ones_count = ones_q;

endmodule

// File: tb/tb_lut_eval_seq.sv
// tb_lut_eval_seq: directed bench for lut_eval_seq (N_IN=6).
// A reference model of the table and sweep timing runs alongside the DUT;
// lookup results are queued when a request is accepted and compared when
// out_valid appears.

module tb_lut_eval_seq;

  localparam int unsigned N_IN  = 6;
  localparam int unsigned CNT_W = 7;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_we;
  logic             cfg_bit;
  logic             in_valid;
  logic [N_IN-1:0]  in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_y;
  logic             sweep_start;
  logic             sweep_busy;
  logic             sweep_done;
  logic [CNT_W-1:0] ones_count;

  lut_eval_seq #(.N_IN(N_IN), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_bit     (cfg_bit),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_y       (out_y),
    .sweep_start (sweep_start),
    .sweep_busy  (sweep_busy),
    .sweep_done  (sweep_done),
    .ones_count  (ones_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_passed = 0;

  // Reference model
  logic [63:0]      m_table = '0;
  int               m_left  = 0;   // busy cycles remaining after the last edge
  logic [CNT_W-1:0] m_ones  = '0;
  logic             m_y     = 1'b0;
  logic             m_v     = 1'b0;
  logic             exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance the model across one edge, clock the DUT, then compare
  task automatic tick();
    logic idle;
    idle = (m_left == 0);
    if (rst) begin
      m_table = '0;
      m_left  = 0;
      m_ones  = '0;
      m_y     = 1'b0;
      m_v     = 1'b0;
      exp_q.delete();
    end else begin
      m_v = in_valid && idle;
      if (m_v) begin
        m_y = m_table[in_data];
        exp_q.push_back(m_y);
      end
      if (idle && cfg_we) m_table = {m_table[62:0], cfg_bit};
      if (m_left > 0) m_left--;
      else if (sweep_start) begin
        m_left = 65;
        m_ones = CNT_W'($countones(m_table));
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_v));
    if (out_valid === 1'b1) begin
      chk("sb_nonempty", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) chk("sb_out_y", 64'(out_y), 64'(exp_q.pop_front()));
    end else if (exp_q.size() != 0) begin
      chk("sb_missing", 64'(exp_q.size()), 64'(0));
      exp_q.delete();
    end
    chk("out_y_hold", 64'(out_y), 64'(m_y));
    chk("in_ready", 64'(in_ready), 64'(m_left == 0));
    chk("sweep_busy", 64'(sweep_busy), 64'(m_left != 0));
    chk("sweep_done", 64'(sweep_done), 64'(m_left == 1));
    if (m_left <= 1) chk("ones_count", 64'(ones_count), 64'(m_ones));
  endtask

  task automatic load64(input logic [63:0] v);
    for (int i = 63; i >= 0; i--) begin
      cfg_we  = 1'b1;
      cfg_bit = v[i];
      tick();
    end
    cfg_we  = 1'b0;
    cfg_bit = 1'b0;
  endtask

  task automatic lookup(input logic [N_IN-1:0] addr, input logic exp);
    in_valid = 1'b1;
    in_data  = addr;
    tick();
    in_valid = 1'b0;
    chk("lookup_valid", 64'(out_valid), 64'(1));
    chk("lookup_y", 64'(out_y), 64'(exp));
  endtask

  // Start a sweep and wait (bounded) for its done pulse
  task automatic run_sweep(input logic [CNT_W-1:0] exp_ones, input bit noisy,
                           input bit with_lookup, input logic lk_exp);
    int n;
    bit seen;
    sweep_start = 1'b1;
    in_valid    = with_lookup;
    in_data     = '0;
    tick();
    sweep_start = 1'b0;
    in_valid    = 1'b0;
    if (with_lookup) begin
      chk("start_lookup_valid", 64'(out_valid), 64'(1));
      chk("start_lookup_y", 64'(out_y), 64'(lk_exp));
    end
    chk("busy_after_start", 64'(sweep_busy), 64'(1));
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      if (noisy && n >= 4 && n < 14) begin
        cfg_we      = 1'b1;
        cfg_bit     = 1'b0;
        in_valid    = 1'b1;
        in_data     = N_IN'(n);
        sweep_start = 1'b1;
      end else begin
        cfg_we      = 1'b0;
        in_valid    = 1'b0;
        sweep_start = 1'b0;
      end
      tick();
      n++;
      if (sweep_done === 1'b1) seen = 1'b1;
    end
    cfg_we      = 1'b0;
    in_valid    = 1'b0;
    sweep_start = 1'b0;
    chk("sweep_done_seen", 64'(seen), 64'(1));
    chk("sweep_done_latency", 64'(n), 64'(64));
    chk("ones_final", 64'(ones_count), 64'(exp_ones));
    tick();
    chk("idle_after_done", 64'(in_ready), 64'(1));
    tick();
    chk("ones_hold", 64'(ones_count), 64'(exp_ones));
  endtask

  initial begin
    cfg_we = 1'b0; cfg_bit = 1'b0; in_valid = 1'b0; in_data = '0; sweep_start = 1'b0;

    // Reset with random inputs
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cfg_we      = 1'($urandom);
      cfg_bit     = 1'($urandom);
      in_valid    = 1'($urandom);
      in_data     = N_IN'($urandom);
      sweep_start = 1'($urandom);
      tick();
    end
    rst = 1'b0; cfg_we = 1'b0; in_valid = 1'b0; sweep_start = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_y", 64'(out_y), 64'(0));
    chk("rst_ones", 64'(ones_count), 64'(0));
    chk("rst_busy", 64'(sweep_busy), 64'(0));
    chk("rst_ready", 64'(in_ready), 64'(1));
    lookup(6'h00, 1'b0);
    lookup(6'h3F, 1'b0);

    // Load 0x8000_0000_0000_0001 and look up
    load64(64'h8000_0000_0000_0001);
    lookup(6'h3F, 1'b1);
    lookup(6'h00, 1'b1);
    lookup(6'h15, 1'b0);

    // Back-to-back lookups
    in_valid = 1'b1; in_data = 6'h3F; tick();
    chk("b2b_y0", 64'(out_y), 64'(1));
    in_data = 6'h15; tick();
    chk("b2b_v1", 64'(out_valid), 64'(1));
    chk("b2b_y1", 64'(out_y), 64'(0));
    in_data = 6'h00; tick();
    chk("b2b_v2", 64'(out_valid), 64'(1));
    chk("b2b_y2", 64'(out_y), 64'(1));
    in_valid = 1'b0; tick();
    chk("b2b_drop", 64'(out_valid), 64'(0));
    chk("b2b_hold", 64'(out_y), 64'(1));

    // Sweep with noise on the ignored inputs
    run_sweep(7'd2, 1'b1, 1'b0, 1'b0);
    lookup(6'h3F, 1'b1);
    lookup(6'h00, 1'b1);
    lookup(6'h01, 1'b0);

    // Reset mid-sweep at index 20
    sweep_start = 1'b1; tick(); sweep_start = 1'b0;
    repeat (20) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_done", 64'(sweep_done), 64'(0));
    chk("mid_rst_ones", 64'(ones_count), 64'(0));
    chk("mid_rst_ready", 64'(in_ready), 64'(1));
    repeat (70) tick();
    lookup(6'h3F, 1'b0);

    // All-ones table
    load64('1);
    run_sweep(7'b1000000, 1'b0, 1'b0, 1'b0);
    lookup(6'h15, 1'b1);

    // Simultaneous config write and lookup
    load64('0);
    cfg_we = 1'b1; cfg_bit = 1'b1; in_valid = 1'b1; in_data = 6'h00;
    tick();
    cfg_we = 1'b0; cfg_bit = 1'b0; in_valid = 1'b0;
    chk("simul_old_table", 64'(out_y), 64'(0));
    lookup(6'h01, 1'b0);
    lookup(6'h00, 1'b1);

    // Sweep start with lookup in the same cycle
    run_sweep(7'd1, 1'b0, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
